// File: rtl/display_filters_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_filters_pkg                                                  |
// | Shared filter indices, raster limits and luma helper.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package display_filters_pkg;

  typedef enum logic [2:0] {
    F_PASS   = 3'd0,
    F_GRAY   = 3'd1,
    F_INV    = 3'd2,
    F_RED    = 3'd3,
    F_GREEN  = 3'd4,
    F_BLUE   = 3'd5,
    F_THRESH = 3'd6,
    F_POSTER = 3'd7
  } filter_e;

  localparam int         c_H_ACTIVE    = 1024;
  localparam int         c_V_ACTIVE    = 768;
  localparam logic [5:0] c_LUMA_THRESH = 6'd32;

  // Red and blue are widened to 6 bits by replicating their MSB so all three
  // channels share one scale; the 8-bit sum cannot overflow (max 252).
  function automatic logic [5:0] luma6(input logic [15:0] p);
    logic [7:0] w_sum;
    w_sum = 8'({p[15:11], p[15]}) + {1'b0, p[10:5], 1'b0} + 8'({p[4:0], p[4]});
    return w_sum[7:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/filter_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | filter_select                                                        |
// | Button edge detectors driving a wrap-around 3-bit up/down selector.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module filter_select (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       left_in,
  input  logic       right_in,
  output logic [2:0] select_out
);

  logic       r_left_prev;
  logic       r_right_prev;
  logic [2:0] r_select;
  logic       w_left_rise;
  logic       w_right_rise;

  assign w_left_rise  = left_in & ~r_left_prev;
  assign w_right_rise = right_in & ~r_right_prev;

  // Simultaneous edges cancel; the 3-bit arithmetic provides the wrap.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_left_prev  <= 1'b0;
      r_right_prev <= 1'b0;
      r_select     <= 3'd0;
    end else begin
      r_left_prev  <= left_in;
      r_right_prev <= right_in;
      if (w_right_rise && !w_left_rise)
        r_select <= r_select + 3'd1;
      else if (w_left_rise && !w_right_rise)
        r_select <= r_select - 3'd1;
    end
  end

  assign select_out = r_select;

endmodule
`default_nettype wire

// File: rtl/display_filter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_filter_bank                                                  |
// | Two-stage RGB565 colour filter with active-area blanking.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module display_filter_bank
  import display_filters_pkg::*;
#(
  parameter int H_ACTIVE = c_H_ACTIVE,
  parameter int V_ACTIVE = c_V_ACTIVE
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [15:0] frame_buff_in,
  input  logic        left_in,
  input  logic        right_in,
  output logic [15:0] pixel_out,
  output logic [2:0]  select_out
);

  localparam logic [10:0] c_H_LIM = 11'(H_ACTIVE);
  localparam logic [9:0]  c_V_LIM = 10'(V_ACTIVE);

  logic [2:0]  w_select;
  logic        w_blank;
  logic [15:0] r_s1_pix;
  logic [5:0]  r_s1_luma;
  logic        r_s1_blank;
  logic [15:0] w_filt;
  logic [15:0] r_pixel;

  filter_select u_filter_select (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .left_in    (left_in),
    .right_in   (right_in),
    .select_out (w_select)
  );

  assign w_blank = (hcount_in >= c_H_LIM) || (vcount_in >= c_V_LIM);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s1_pix   <= 16'h0000;
      r_s1_luma  <= 6'd0;
      r_s1_blank <= 1'b0;
    end else begin
      r_s1_pix   <= frame_buff_in;
      r_s1_luma  <= luma6(frame_buff_in);
      r_s1_blank <= w_blank;
    end
  end

  // The mux reads the live selection, so a change may hit a pixel already in stage 1.
  always_comb begin
    w_filt = r_s1_pix;
    case (filter_e'(w_select))
      F_PASS:   w_filt = r_s1_pix;
      F_GRAY:   w_filt = {r_s1_luma[5:1], r_s1_luma, r_s1_luma[5:1]};
      F_INV:    w_filt = ~r_s1_pix;
      F_RED:    w_filt = {r_s1_pix[15:11], 11'b0};
      F_GREEN:  w_filt = {5'b0, r_s1_pix[10:5], 5'b0};
      F_BLUE:   w_filt = {11'b0, r_s1_pix[4:0]};
      F_THRESH: w_filt = (r_s1_luma >= c_LUMA_THRESH) ? 16'hFFFF : 16'h0000;
      F_POSTER: w_filt = {r_s1_pix[15:14], 3'b0, r_s1_pix[10:9], 4'b0, r_s1_pix[4:3], 3'b0};
      default:  w_filt = r_s1_pix;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      r_pixel <= 16'h0000;
    else
      r_pixel <= r_s1_blank ? 16'h0000 : w_filt;
  end

  assign pixel_out  = r_pixel;
  assign select_out = w_select;

endmodule
`default_nettype wire

// File: tb/tb_display_filter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_display_filter_bank                                               |
// | Scoreboard bench for the filter pipeline and the selection counter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_display_filter_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount = 11'd0;
  logic [9:0]  vcount = 10'd0;
  logic [15:0] pix_in = 16'h0000;
  logic        left = 1'b0;
  logic        right = 1'b0;
  logic [15:0] pixel_out;
  logic [2:0]  select_out;

  typedef struct {
    logic [15:0] pix;
    int          due;
  } sb_t;

  sb_t sb[$];
  int  cyc = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  int  exp_sel = 0;

  display_filter_bank dut (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .hcount_in     (hcount),
    .vcount_in     (vcount),
    .frame_buff_in (pix_in),
    .left_in       (left),
    .right_in      (right),
    .pixel_out     (pixel_out),
    .select_out    (select_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] p, input int sel, input int h, input int v);
    int r, g, b, r6, b6, y;
    logic [15:0] o;
    if (h >= 1024 || v >= 768) return 16'h0000;
    r  = int'(p[15:11]);
    g  = int'(p[10:5]);
    b  = int'(p[4:0]);
    r6 = r * 2 + r / 16;
    b6 = b * 2 + b / 16;
    y  = (r6 + 2 * g + b6) / 4;
    case (sel)
      0:       o = p;
      1:       o = 16'((y / 2) * 2048 + y * 32 + y / 2);
      2:       o = ~p;
      3:       o = 16'(r * 2048);
      4:       o = 16'(g * 32);
      5:       o = 16'(b);
      6:       o = (y >= 32) ? 16'hFFFF : 16'h0000;
      default: o = 16'((r / 8) * 8 * 2048 + (g / 16) * 16 * 32 + (b / 8) * 8);
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      check("pixel", pixel_out, e.pix);
    end
  end

  task automatic drive_pix(input int h, input int v, input logic [15:0] p);
    hcount = 11'(h);
    vcount = 10'(v);
    pix_in = p;
    sb.push_back('{model(p, exp_sel, h, v), cyc + 2});
    @(negedge clk);
  endtask

  task automatic stream(input int h, input int v, input logic [15:0] p, input int n);
    for (int i = 0; i < n; i++) drive_pix(h, v, p);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_right();
    right = 1'b1;
    @(negedge clk);
    exp_sel = (exp_sel + 1) % 8;
    check("sel_up", 16'(select_out), 16'(exp_sel));
    right = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_left();
    left = 1'b1;
    @(negedge clk);
    exp_sel = (exp_sel + 7) % 8;
    check("sel_dn", 16'(select_out), 16'(exp_sel));
    left = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_sel(input int t);
    while (exp_sel != t) pulse_right();
  endtask

  initial begin
    int hs[9];
    int vs[8];
    hs = '{0, 1, 512, 1022, 1023, 1024, 1025, 1500, 2047};
    vs = '{0, 1, 383, 766, 767, 768, 769, 1023};

    #3;
    check("rst_pix", pixel_out, 16'h0000);
    check("rst_sel", 16'(select_out), 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Boundary raster sweep in pass-through mode.
    foreach (vs[j]) foreach (hs[i]) drive_pix(hs[i], vs[j], 16'h8210);
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) pulse_right();
    pulse_left();
    for (int i = 0; i < 7; i++) pulse_left();

    // Every filter on the reference pixel, plus blanking and threshold edges.
    for (int s = 0; s < 8; s++) begin
      set_sel(s);
      drive_pix(100, 100, 16'h8216);
      drive_pix(1024, 100, 16'h8216);
      drive_pix(100, 768, 16'h8216);
      drive_pix(100, 100, 16'h83F0);
      drive_pix(100, 100, 16'h83D0);
      stream(1023, 767, 16'hFFFF, 2);
    end
    set_sel(1);
    stream(100, 100, 16'h8216, 2);
    check("gray_ref", model(16'h8216, 1, 100, 100), 16'h6B6D);
    set_sel(2);
    stream(100, 100, 16'h8216, 2);
    set_sel(6);
    stream(100, 100, 16'h8216, 2);
    pulse_left(); pulse_left(); pulse_left();
    stream(100, 100, 16'h8216, 2);

    right = 1'b1;
    repeat (50) @(negedge clk);
    exp_sel = (exp_sel + 1) % 8;
    check("hold_right", 16'(select_out), 16'(exp_sel));
    right = 1'b0;
    @(negedge clk);
    check("hold_release", 16'(select_out), 16'(exp_sel));
    left  = 1'b1;
    right = 1'b1;
    @(negedge clk);
    check("both_edges", 16'(select_out), 16'(exp_sel));
    left  = 1'b0;
    right = 1'b0;
    @(negedge clk);

    set_sel(5);
    stream(100, 100, 16'h8216, 4);
    #2;
    check("pre_rst_pix", pixel_out, 16'h0016);
    rst_n = 1'b0;
    #1;
    check("async_rst_pix", pixel_out, 16'h0000);
    check("async_rst_sel", 16'(select_out), 16'h0000);
    sb.delete();
    exp_sel = 0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_pix(10, 10, 16'h8216);
    check("rst_lat1", pixel_out, 16'h0000);
    stream(10, 10, 16'h8216, 3);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) check("sb_drain", 16'(sb.size()), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_filter_bank.md
# display_filter_bank

Per-pixel colour-filter stage between the frame buffer read port and the video output path of the 1024x768 display pipeline. It takes the RGB565 pixel fetched for the current raster position and applies one of eight filters, chosen by the user. Left/right buttons step the selection down or up. Output is blanked outside the active area.

## Interface
Parameters:
- H_ACTIVE, 1024, active pixels per line.
- V_ACTIVE, 768, active lines per frame.

Ports:
- clk_in  input  1  system/pixel clock.
- rst_in  input  1  reset. Active-low and asynchronous.
- hcount_in  input  11  horizontal raster position of frame_buff_in.
- vcount_in  input  10  vertical raster position of frame_buff_in.
- frame_buff_in  input  16  RGB565 pixel: r5=[15:11], g6=[10:5], b5=[4:0].
- left_in  input  1  debounced button level. A rising edge decrements the selection.
- right_in  input  1  debounced button level. A rising edge increments the selection.
- pixel_out  output  16  filtered RGB565 pixel.
- select_out  output  3  current filter index.

## Operation
Filter selection:
- A 3-bit register holds the selection. It resets to 0.
- Each input has a previous-value register, reset to 0. A rising edge is detected when the current sample is 1 and the previous sample is 0.
- A right edge adds 1 to the selection. 7 wraps to 0.
- A left edge subtracts 1. 0 wraps to 7.
- If a left edge and a right edge occur in the same cycle, the selection does not change.
- A held button produces exactly one step.

Filters, defined on p = frame_buff_in:
- Luma: r6={r5,r5[4]}, b6={b5,b5[4]}, y6=(r6+2*g6+b6)>>2. Compute in 8 bits, then truncate.
- 0 pass: p.
- 1 gray: {y6[5:1], y6, y6[5:1]}.
- 2 invert: ~p.
- 3 red: {r5, 11'b0}.
- 4 green: {5'b0, g6, 5'b0}.
- 5 blue: {11'b0, b5}.
- 6 threshold: 16'hFFFF if y6>=32, else 16'h0000.
- 7 posterize: {r5[4:3],3'b0, g6[5:4],4'b0, b5[4:3],3'b0}.

Blanking:
- If hcount_in>=H_ACTIVE or vcount_in>=V_ACTIVE, pixel_out is 16'h0000, whatever the filter.
- The positions 1023 and 767 are active.

## Timing
- Pixel latency is 2 cycles.
- Stage 1 registers p, luma and the blank flag.
- Stage 2 registers pixel_out, using the filter mux on stage-1 data.
- hcount_in/vcount_in/frame_buff_in sampled at clock edge N appear filtered at edge N+2.
- select_out updates at the same edge that samples the rising edge: the first edge at which right_in/left_in reads 1 after reading 0.
- Stage 2 uses the select register value current at that edge. A selection change can therefore affect a pixel already in stage 1; this is acceptable.
- While rst_in is low:
  - pixel_out=0, select_out=0.
  - All pipeline registers and both previous-value registers are 0.
  - The first valid pixel_out appears 2 edges after deassertion.
- Reset asserted mid-frame clears everything immediately.
- An X on left_in/right_in must not be generated from internal state. Benches drive both inputs to 0 after reset.

## Structure
- Shared package display_filters_pkg holds:
  - The filter index enum: F_PASS, F_GRAY, F_INV, F_RED, F_GREEN, F_BLUE, F_THRESH, F_POSTER.
  - H_ACTIVE/V_ACTIVE defaults.
  - The 32 threshold constant.
- Sub-module filter_select holds the two edge detectors and the wrap-around up/down counter, and outputs select_out.
- The pixel pipeline and filter mux stay in the top.

## Test plan
- Full raster with frame_buff_in=16'h8210, select 0: pixel_out=16'h8210 two cycles after every in-area position, and 16'h0000 for h>=1024 or v>=768.
- Seven one-cycle right_in pulses, separated by low cycles: select_out steps 1,2,...,7. An eighth pulse wraps to 0.
- Seven left_in pulses starting from 7: select_out steps down to 0. One more pulse wraps to 7.
- frame_buff_in=16'h8216 at (100,100) gives, two cycles later:
  - select 1: 16'h6B6D (y6=27).
  - select 2: 16'h7DE9.
  - select 6: 16'h0000.
  - select 3: 16'h8000.
- right_in held high for 50 cycles: select_out increments once. left_in and right_in rising together: no change.
- Assert rst_in low mid-stream with select=5: pixel_out and select_out read 0 at once, without waiting for a clock. After release, the pass-through output resumes at latency 2.
